// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and sweep-FSM state type for the multi-port register file.
package reg_file_pkg;
   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;
   localparam int RF_NRD   = 2;
   typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_e;
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits for pending writebacks, with set-over-clear priority,
// sweep clearing and per-read-port lookup; x0 is never busy.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NREGS = RF_NREGS,
   parameter int NRD   = RF_NRD,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_clr,
   input  logic [AW-1:0]     i_clr_addr,
   input  logic              i_set,
   input  logic [AW-1:0]     i_set_addr,
   input  logic              i_sweep,
   input  logic [AW-1:0]     i_sweep_idx,
   input  logic [NRD*AW-1:0] i_rs_addr,
   output logic [NRD-1:0]    o_busy
);
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
      if (i_sweep) w_busy_nxt[i_sweep_idx] = 1'b0;
      // issue applied last so a same-cycle writeback to that register leaves it busy
      if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_busy <= '0;
      else r_busy <= w_busy_nxt;
   for (genvar k = 0; k < NRD; k++) begin : g_lk
      assign o_busy[k] = r_busy[i_rs_addr[k*AW +: AW]];
   end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: NRD-read/1-write register file with x0 hardwired to zero, busy scoreboard and clear sweep.
// Optional REG_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int NREGS = RF_NREGS,
   parameter int NRD   = RF_NRD,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic                we,
   input  logic [AW-1:0]       rd_addr,
   input  logic [XLEN-1:0]     rd_data,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_addr,
   input  logic                clr_req,
   output logic                ready,
   output logic                clr_done
);
   logic [XLEN-1:0] r_regs [NREGS];
   rf_state_e       r_state, w_state_nxt;
   logic [AW-1:0]   r_idx;
   logic            w_wr, w_sweep;
   logic [NRD-1:0]  w_sb_busy;
   assign ready    = r_state == RF_IDLE;
   assign clr_done = r_state == RF_DONE;
   assign w_sweep  = r_state == RF_CLEAR;
   assign w_wr     = ready && we && rd_addr != '0;
   always_comb begin
      w_state_nxt = r_state;
      if (ready && clr_req) w_state_nxt = RF_CLEAR;
      else if (w_sweep && r_idx == AW'(NREGS - 1)) w_state_nxt = RF_DONE;
      else if (clr_done) w_state_nxt = RF_IDLE;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state <= RF_IDLE;
         r_idx   <= AW'(1);
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_sweep ? r_idx + AW'(1) : AW'(1);
      end
   // writes only happen in IDLE, so they never collide with the sweep
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      else if (w_wr) r_regs[rd_addr] <= rd_data;
      else if (w_sweep) r_regs[r_idx] <= '0;
   reg_file_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_clr      (w_wr),
      .i_clr_addr (rd_addr),
      .i_set      (ready && sb_set),
      .i_set_addr (sb_addr),
      .i_sweep    (w_sweep),
      .i_sweep_idx(r_idx),
      .i_rs_addr  (rs_addr),
      .o_busy     (w_sb_busy)
   );
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_raddr;
      logic [XLEN-1:0] w_rdata;
      assign w_raddr = rs_addr[k*AW +: AW];
      assign w_rdata = (w_raddr == '0) ? '0 : r_regs[w_raddr];
`ifdef REG_FILE_BYPASS_EN
      logic w_hit;
      assign w_hit                    = w_wr && rd_addr == w_raddr;
      assign rs_data[k*XLEN +: XLEN] = w_hit ? rd_data : w_rdata;
      assign rs_busy[k]               = w_sb_busy[k] && !w_hit;
`else
      assign rs_data[k*XLEN +: XLEN] = w_rdata;
      assign rs_busy[k]               = w_sb_busy[k];
`endif
   end
endmodule
